// File: rtl/xy_dac_pacer.sv
// XY DAC pacer: buffers linedraw points and replays them to the DAC
// at a fixed dwell, blanking the beam when the point stream starves.
module xy_dac_pacer #(
    parameter int OUT_WIDTH   = 8,
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 4,
    parameter int BLANK_DELAY = 8,
    parameter int AF_MARGIN   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [OUT_WIDTH-1:0]       xin,
    input  logic [OUT_WIDTH-1:0]       yin,
    input  logic                       clr_ovf,
    output logic [OUT_WIDTH-1:0]       dac_x,
    output logic [OUT_WIDTH-1:0]       dac_y,
    output logic                       dac_ld,
    output logic                       blank,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int DW = $clog2(HOLD_CYCLES);
    localparam int SW = $clog2(BLANK_DELAY + 1);
    localparam int EW = 2 * OUT_WIDTH;

    localparam logic [PW-1:0] AF_LEVEL  = PW'(DEPTH - AF_MARGIN);
    localparam logic [DW-1:0] DWELL_INI = DW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] STARVE_MX = SW'(BLANK_DELAY);

    typedef enum logic [0:0] {
        IDLE,
        HOLD
    } state_t;

    logic [EW-1:0] mem [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] count_n;

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    state_t        state;
    state_t        state_n;
    logic [DW-1:0] dwell;
    logic [DW-1:0] dwell_n;
    logic [SW-1:0] starve;
    logic [SW-1:0] starve_n;
    logic          blank_n;
    logic [EW-1:0] head;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) &&
                   (wptr[AW] != rptr[AW]);
    assign head  = mem[rptr[AW-1:0]];

    // A full FIFO still accepts a point when the head leaves this cycle.
    assign push = wr && (!full || pop);
    assign drop = wr && full && !pop;

    always_comb begin
        count_n = count;
        unique case ({push, pop})
            2'b10:   count_n = count + PW'(1);
            2'b01:   count_n = count - PW'(1);
            default: count_n = count;
        endcase
    end

    always_comb begin
        state_n  = state;
        dwell_n  = dwell;
        starve_n = starve;
        blank_n  = blank;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    blank_n  = 1'b0;
                    starve_n = '0;
                    dwell_n  = DWELL_INI;
                    state_n  = HOLD;
                end else begin
                    if (starve != STARVE_MX)
                        starve_n = starve + SW'(1);
                    if (starve_n == STARVE_MX)
                        blank_n = 1'b1;
                end
            end
            HOLD: begin
                dwell_n = dwell - DW'(1);
                if (dwell <= DW'(1))
                    state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[AW-1:0]] <= {xin, yin};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
            count       <= count_n;
            almost_full <= (count_n >= AF_LEVEL);
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            dwell  <= '0;
            starve <= '0;
            blank  <= 1'b1;
            dac_x  <= '0;
            dac_y  <= '0;
            dac_ld <= 1'b0;
        end else begin
            state  <= state_n;
            dwell  <= dwell_n;
            starve <= starve_n;
            blank  <= blank_n;
            dac_ld <= pop;
            if (pop) begin
                dac_x <= head[EW-1:OUT_WIDTH];
                dac_y <= head[OUT_WIDTH-1:0];
            end
        end
    end

endmodule
